// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the counter sequencing controller: the controller
//   state type (3-bit encoding) and the default data width.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl_if
//   Bundles the command side (START/STOP/HOLD/PRESET/TERM, BUSY/DONE) and the
//   counter side (D/LD/EN/OE, Q_IN feedback) of the sequencing controller.
//   master : the controller (drives EN/LD/OE/D/BUSY/DONE)
//   slave  : the environment (command source plus the controlled counter)
// -----------------------------------------------------------------------------
interface counter_seq_ctrl_if
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             START;
    logic             STOP;
    logic             HOLD;
    logic [WIDTH-1:0] PRESET;
    logic [WIDTH-1:0] TERM;
    logic [WIDTH-1:0] Q_IN;
    logic             EN;
    logic             LD;
    logic             OE;
    logic [WIDTH-1:0] D;
    logic             BUSY;
    logic             DONE;

    modport master (
        input  START, STOP, HOLD, PRESET, TERM, Q_IN,
        output EN, LD, OE, D, BUSY, DONE
    );

    modport slave (
        output START, STOP, HOLD, PRESET, TERM, Q_IN,
        input  EN, LD, OE, D, BUSY, DONE
    );

endinterface

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//   Upstream control stage for a loadable counter with output enable. A START
//   latches preset and terminal values, loads the counter, lets it run until
//   it reaches the terminal value, pulses DONE and keeps OE high for a
//   SHOW_CYC-cycle display window. STOP aborts, HOLD pauses.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous reset, active low
//     bus    counter_seq_ctrl_if.master (command inputs, counter controls,
//            Q_IN feedback, BUSY/DONE status)
//   All outputs are Moore outputs decoded from registered state.
// -----------------------------------------------------------------------------
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int SHOW_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    counter_seq_ctrl_if.master        bus
);

    localparam int              SC_W      = $clog2(SHOW_CYC) + 1;
    localparam logic [SC_W-1:0] SHOW_LAST = SC_W'(SHOW_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pre_r;
    logic [WIDTH-1:0] term_r;
    logic [WIDTH-1:0] term_m1;
    logic [SC_W-1:0]  show_cnt;

    // The counter advances on the same edge on which we decide, so the stop
    // decision is taken one value early; wraps to all-ones for TERM=0.
    assign term_m1 = term_r - WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pre_r    <= '0;
            term_r   <= '0;
            show_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.START) begin
                pre_r  <= bus.PRESET;
                term_r <= bus.TERM;
            end
            if (state != ST_DONE && state_nxt == ST_DONE) begin
                show_cnt <= '0;
            end else if (state == ST_DONE) begin
                show_cnt <= show_cnt + SC_W'(1);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        bus.EN    = 1'b0;
        bus.LD    = 1'b0;
        bus.OE    = 1'b0;
        bus.BUSY  = 1'b1;
        bus.DONE  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                bus.BUSY = 1'b0;
                if (bus.START) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                bus.EN = 1'b1;
                bus.LD = 1'b1;
                if (bus.STOP)             state_nxt = ST_IDLE;
                else if (pre_r == term_r) state_nxt = ST_DONE;
                else                      state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                bus.EN = 1'b1;
                bus.OE = 1'b1;
                // STOP beats terminal beats HOLD.
                if (bus.STOP)                 state_nxt = ST_IDLE;
                else if (bus.Q_IN == term_m1) state_nxt = ST_DONE;
                else if (bus.HOLD)            state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                bus.OE = 1'b1;
                if (bus.STOP)       state_nxt = ST_IDLE;
                else if (!bus.HOLD) state_nxt = ST_COUNT;
            end
            ST_DONE: begin
                bus.OE   = 1'b1;
                bus.DONE = (show_cnt == '0);
                if (show_cnt == SHOW_LAST) state_nxt = ST_IDLE;
            end
            default: begin
                bus.BUSY  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.D = pre_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_seq_ctrl
//   Drives counter_seq_ctrl with a behavioural loadable counter on Q_IN.
//   Each transaction is summarised (cycle counts of EN/LD/OE/BUSY, DONE pulses,
//   final counter value) and compared with a table of hand-derived values or
//   with a transaction-level model for randomized transactions.
// -----------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    localparam int WIDTH    = 4;
    localparam int SHOW_CYC = 2;
    localparam int MODV     = 1 << WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    counter_seq_ctrl #(.WIDTH(WIDTH), .SHOW_CYC(SHOW_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Controlled counter: load has priority over enable.
    logic [WIDTH-1:0] q = '0;
    always @(posedge clk) begin
        if (bus.LD)      q <= bus.D;
        else if (bus.EN) q <= q + WIDTH'(1);
    end
    assign bus.Q_IN = q;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int preset, term, hold_cyc, hold_len, stop_cyc;
        int en, oe, busy, done, q;
    } vec_t;

    typedef struct {
        int en, ld, oe, busy, done, q_done, q_final, d_at_ld;
        bit timeout;
    } obs_t;

    // Cycle 0 presents START; cycle 1 is the load cycle; HOLD and STOP are
    // scheduled in absolute cycles from there.
    task automatic run_txn(input int preset, input int term, input int hold_cyc, input int hold_len,
                           input int stop_cyc, input bit rand_start, output obs_t o);
        bit seen_idle = 1'b0;
        o = '{default: 0};
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                if (!bus.BUSY) begin
                    seen_idle = 1'b1;
                    break;
                end
                o.busy++;
                if (bus.EN) o.en++;
                if (bus.OE) o.oe++;
                if (bus.LD) begin
                    o.ld++;
                    o.d_at_ld = int'(bus.D);
                end
                if (bus.DONE) begin
                    o.done++;
                    o.q_done = int'(q);
                end
            end
            bus.START  = (cyc == 0) ? 1'b1 : (rand_start ? 1'($urandom_range(1)) : 1'b1);
            bus.PRESET = (cyc == 0) ? WIDTH'(preset) : WIDTH'($urandom);
            bus.TERM   = (cyc == 0) ? WIDTH'(term)   : WIDTH'($urandom);
            bus.HOLD   = (hold_len > 0 && cyc >= hold_cyc && cyc < hold_cyc + hold_len);
            bus.STOP   = (stop_cyc > 0 && cyc == stop_cyc);
        end
        o.timeout  = !seen_idle;
        bus.START  = 1'b0;
        bus.HOLD   = 1'b0;
        bus.STOP   = 1'b0;
        o.q_final  = int'(q);
    endtask

    // Transaction-level expectation: number of count steps is the modular
    // distance preset->term; STOP truncates, an effective HOLD adds its length.
    task automatic model(input int preset, input int term, input int hold_cyc, input int hold_len,
                         input int stop_cyc, output vec_t v);
        int steps = ((term - preset) % MODV + MODV) % MODV;
        int pause;
        v = '{preset, term, hold_cyc, hold_len, stop_cyc, 0, 0, 0, 0, 0};
        if (stop_cyc == 1) begin
            v.en = 1; v.oe = 0; v.busy = 1; v.done = 0; v.q = preset;
        end else if (stop_cyc >= 2 && stop_cyc - 2 < steps) begin
            v.en   = stop_cyc;
            v.oe   = stop_cyc - 1;
            v.busy = stop_cyc;
            v.done = 0;
            v.q    = (preset + stop_cyc - 1) % MODV;
        end else begin
            pause  = (hold_len > 0 && hold_cyc >= 2 && hold_cyc - 2 < steps - 1) ? hold_len : 0;
            v.en   = steps + 1;
            v.oe   = steps + pause + SHOW_CYC;
            v.busy = 1 + steps + pause + SHOW_CYC;
            v.done = 1;
            v.q    = term;
        end
    endtask

    task automatic check_obs(input string tag, input vec_t v, input obs_t o);
        check({tag, " timeout"}, 32'(o.timeout), 0);
        check({tag, " en_cycles"}, o.en, v.en);
        check({tag, " ld_cycles"}, o.ld, 1);
        check({tag, " d_at_ld"}, o.d_at_ld, v.preset);
        check({tag, " oe_cycles"}, o.oe, v.oe);
        check({tag, " busy_cycles"}, o.busy, v.busy);
        check({tag, " done_pulses"}, o.done, v.done);
        check({tag, " q_final"}, o.q_final, v.q);
        if (v.done > 0) check({tag, " q_at_done"}, o.q_done, v.term);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t exp_v;
        obs_t o;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t exp_v;
        obs_t o;
        int   preset, term, mode, steps, hold_cyc, hold_len, stop_cyc;

        // preset term hcyc hlen stop | en oe busy done q
        vecs.push_back('{ 3,  7, 0, 0, 0,  5,  6,  7, 1,  7}); // basic run
        vecs.push_back('{ 5,  5, 0, 0, 0,  1,  2,  3, 1,  5}); // preset==term
        vecs.push_back('{14,  1, 0, 0, 0,  4,  5,  6, 1,  1}); // wrap-around
        vecs.push_back('{ 0,  9, 6, 3, 0, 10, 14, 15, 1,  9}); // HOLD 3 cycles at Q=4
        vecs.push_back('{ 0,  9, 0, 0, 7,  7,  6,  7, 0,  6}); // STOP at Q=5
        vecs.push_back('{12,  0, 0, 0, 0,  5,  6,  7, 1,  0}); // TERM=0
        vecs.push_back('{ 1,  0, 0, 0, 0, 16, 17, 18, 1,  0}); // longest run
        vecs.push_back('{ 8, 12, 0, 0, 1,  1,  0,  1, 0,  8}); // STOP in LOAD
        vecs.push_back('{ 0,  9, 4, 3, 6,  4,  5,  6, 0,  3}); // STOP in PAUSE
        vecs.push_back('{ 0,  9, 3, 1, 3,  3,  2,  3, 0,  2}); // STOP beats HOLD
        vecs.push_back('{ 3,  7, 5, 2, 0,  5,  6,  7, 1,  7}); // terminal beats HOLD
        vecs.push_back('{ 5,  5, 0, 0, 2,  1,  2,  3, 1,  5}); // STOP in DONE ignored

        bus.START  = 1'b0;
        bus.STOP   = 1'b0;
        bus.HOLD   = 1'b0;
        bus.PRESET = '0;
        bus.TERM   = '0;

        // Reset state, observed while reset is still asserted.
        #1;
        check("reset EN",   32'(bus.EN),   0);
        check("reset LD",   32'(bus.LD),   0);
        check("reset OE",   32'(bus.OE),   0);
        check("reset BUSY", 32'(bus.BUSY), 0);
        check("reset DONE", 32'(bus.DONE), 0);
        check("reset D",    32'(bus.D),    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors; START is held high throughout, so every
        // START seen while busy must be ignored.
        foreach (vecs[i]) begin
            run_txn(vecs[i].preset, vecs[i].term, vecs[i].hold_cyc, vecs[i].hold_len,
                    vecs[i].stop_cyc, 1'b0, o);
            check_obs($sformatf("vec%0d", i), vecs[i], o);
        end

        // Asynchronous reset in the middle of COUNT.
        @(negedge clk);
        bus.START  = 1'b1;
        bus.PRESET = WIDTH'(2);
        bus.TERM   = WIDTH'(11);
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst pre EN", 32'(bus.EN), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst EN",   32'(bus.EN),   0);
        check("midrst LD",   32'(bus.LD),   0);
        check("midrst OE",   32'(bus.OE),   0);
        check("midrst BUSY", 32'(bus.BUSY), 0);
        check("midrst DONE", 32'(bus.DONE), 0);
        check("midrst D",    32'(bus.D),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst BUSY", 32'(bus.BUSY), 0);

        // Randomized transactions against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            preset   = int'($urandom_range(MODV - 1));
            term     = int'($urandom_range(MODV - 1));
            mode     = int'($urandom_range(2));
            steps    = ((term - preset) % MODV + MODV) % MODV;
            hold_cyc = 0;
            hold_len = 0;
            stop_cyc = 0;
            if (mode == 1) begin
                hold_cyc = 2 + int'($urandom_range(steps));
                hold_len = int'($urandom_range(3, 1));
            end else if (mode == 2) begin
                stop_cyc = 1 + int'($urandom_range(steps + 1));
            end
            model(preset, term, hold_cyc, hold_len, stop_cyc, exp_v);
            run_txn(preset, term, hold_cyc, hold_len, stop_cyc, 1'b1, o);
            check_obs($sformatf("rnd%0d p%0d t%0d h%0d/%0d s%0d", n, preset, term,
                                hold_cyc, hold_len, stop_cyc), exp_v, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
